// File: rtl/tdc_word_decoder.sv
// TDC back end: samples ripple count and thermometer phase each FREF edge and
// produces tdc_word, ckv_delta and a frequency-window flag. Optional TDC_BUBBLE_CORR_EN.
module tdc_word_decoder #(
    parameter int WARMUP_CYCLES = 4,
    parameter int DELTA_TOL     = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic [6:0]  ripple_count,
    input  logic [15:0] phase,
    input  logic [6:0]  fcw_int,
    output logic [11:0] tdc_word,
    output logic        tdc_valid,
    output logic [6:0]  ckv_delta,
    output logic        freq_ok,
    output logic        therm_sat
);

    localparam int CW = $clog2(WARMUP_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, WARMUP, RUN} state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;

    // S1 registers
    logic [6:0]  r1, r1_prev;
    logic [15:0] p1;
    logic        tag1;
    // S2 registers
    logic [6:0]  r2, d2;
    logic [4:0]  n2;
    logic        tag2;

    logic [15:0] taps;
    logic [4:0]  n_c;
    logic [4:0]  frac_c;
    logic [6:0]  diff_c, mag_c;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        if (!en) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
        end else begin
            case (state)
                IDLE: begin
                    state_nxt = WARMUP;
                    cnt_nxt   = '0;
                end
                WARMUP: begin
                    if (cnt == CW'(WARMUP_CYCLES - 1)) begin
                        state_nxt = RUN;
                        cnt_nxt   = '0;
                    end else begin
                        cnt_nxt = cnt + 1'b1;
                    end
                end
                RUN:     state_nxt = RUN;
                default: state_nxt = IDLE;
            endcase
        end
    end

    // NOTE: all sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Bubble correction uses p[-1]=1 and p[16]=0 as the fixed ends of the line.
    always_comb begin
        taps = p1;
`ifdef TDC_BUBBLE_CORR_EN
        for (int i = 0; i < 16; i++) begin
            logic a, b, c;
            a = (i == 0)  ? 1'b1 : p1[i-1];
            b = p1[i];
            c = (i == 15) ? 1'b0 : p1[i+1];
            taps[i] = (a & b) | (a & c) | (b & c);
        end
`endif
        n_c = '0;
        for (int i = 0; i < 16; i++) begin
            n_c = n_c + 5'(taps[i]);
        end
    end

    always_comb begin
        frac_c = (n2 == 5'd16) ? 5'd31 : {n2[3:0], 1'b0};
        diff_c = d2 - fcw_int;
        mag_c  = diff_c[6] ? (7'd0 - diff_c) : diff_c;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r1        <= '0;
            r1_prev   <= '0;
            p1        <= '0;
            tag1      <= 1'b0;
            r2        <= '0;
            d2        <= '0;
            n2        <= '0;
            tag2      <= 1'b0;
            tdc_word  <= '0;
            tdc_valid <= 1'b0;
            ckv_delta <= '0;
            freq_ok   <= 1'b0;
            therm_sat <= 1'b0;
        end else begin
            r1        <= ripple_count;
            r1_prev   <= r1;
            p1        <= phase;
            tag1      <= (state == RUN);

            r2        <= r1;
            d2        <= r1 - r1_prev;
            n2        <= n_c;
            tag2      <= tag1;

            tdc_word  <= {r2, frac_c};
            tdc_valid <= tag2;
            ckv_delta <= d2;
            freq_ok   <= tag2 & (mag_c <= 7'(DELTA_TOL));
            therm_sat <= (n2 == 5'd16);
        end
    end

endmodule

// File: tb/tb_tdc_word_decoder.sv
// Bench for tdc_word_decoder: directed table, hand sequences and a randomized
// run checked against a sample-history reference model.
module tb_tdc_word_decoder;

    localparam int WARMUP_CYCLES = 4;
    localparam int DELTA_TOL     = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic [6:0]  ripple_count;
    logic [15:0] phase;
    logic [6:0]  fcw_int;
    logic [11:0] tdc_word;
    logic        tdc_valid;
    logic [6:0]  ckv_delta;
    logic        freq_ok;
    logic        therm_sat;

    tdc_word_decoder #(.WARMUP_CYCLES(WARMUP_CYCLES), .DELTA_TOL(DELTA_TOL)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .ripple_count(ripple_count),
        .phase(phase), .fcw_int(fcw_int), .tdc_word(tdc_word), .tdc_valid(tdc_valid),
        .ckv_delta(ckv_delta), .freq_ok(freq_ok), .therm_sat(therm_sat)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: history of every captured sample since reset.
    int q_r[$];
    int q_p[$];
    int q_tag[$];
    int run_cnt;
    bit model_chk;

    typedef struct {
        int r;
        int p;
        int frac;
        int sat;
        int delta;
        int ok;
    } vec_t;

    vec_t tbl[8];

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int bit_of(input int v, input int i);
        if (i < 0)  return 1;
        if (i > 15) return 0;
        return (v >> i) & 1;
    endfunction

    function automatic int model_n(input int p);
        int n = 0;
        for (int i = 0; i < 16; i++) begin
`ifdef TDC_BUBBLE_CORR_EN
            if (bit_of(p, i - 1) + bit_of(p, i) + bit_of(p, i + 1) >= 2) n++;
`else
            n += bit_of(p, i);
`endif
        end
        return n;
    endfunction

    function automatic int frac_of(input int n);
        return (n == 16) ? 31 : 2 * n;
    endfunction

    task automatic model_reset();
        q_r.delete();
        q_p.delete();
        q_tag.delete();
        run_cnt = 0;
    endtask

    task automatic all_zero(input string tag);
        check({tag, "_word"},  int'(tdc_word), 0);
        check({tag, "_valid"}, int'(tdc_valid), 0);
        check({tag, "_delta"}, int'(ckv_delta), 0);
        check({tag, "_ok"},    int'(freq_ok), 0);
        check({tag, "_sat"},   int'(therm_sat), 0);
    endtask

    // One clk edge: record the sample, advance the enable history, compare #1 later.
    task automatic edge_step();
        int s, prev, n, delta, diff;
        @(posedge clk);
        q_tag.push_back((run_cnt >= WARMUP_CYCLES + 1) ? 1 : 0);
        q_r.push_back(int'(ripple_count));
        q_p.push_back(int'(phase));
        run_cnt = en ? run_cnt + 1 : 0;
        #1;
        if (model_chk && q_r.size() >= 3) begin
            s     = q_r.size() - 3;
            prev  = (s > 0) ? q_r[s-1] : 0;
            n     = model_n(q_p[s]);
            delta = (q_r[s] - prev) & 127;
            diff  = (delta - int'(fcw_int)) & 127;
            if (diff >= 64) diff -= 128;
            check("m_word",  int'(tdc_word), q_r[s] * 32 + frac_of(n));
            check("m_valid", int'(tdc_valid), q_tag[s]);
            check("m_delta", int'(ckv_delta), delta);
            check("m_sat",   int'(therm_sat), (n == 16) ? 1 : 0);
            check("m_ok",    int'(freq_ok),
                  (q_tag[s] != 0 && diff <= DELTA_TOL && diff >= -DELTA_TOL) ? 1 : 0);
        end
    endtask

    task automatic step_ripple(input int inc);
        ripple_count = 7'(int'(ripple_count) + inc);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int x;
        tbl[0] = '{r: 120, p: 'h00FF, frac: 16, sat: 0, delta: 12, ok: 1};
        tbl[1] = '{r: 4,   p: 'hFFFF, frac: 31, sat: 1, delta: 12, ok: 1};
        tbl[2] = '{r: 19,  p: 'h0000, frac: 0,  sat: 0, delta: 15, ok: 0};
`ifdef TDC_BUBBLE_CORR_EN
        tbl[3] = '{r: 29,  p: 'h00F7, frac: 16, sat: 0, delta: 10, ok: 1};
`else
        tbl[3] = '{r: 29,  p: 'h00F7, frac: 14, sat: 0, delta: 10, ok: 1};
`endif
        tbl[4] = '{r: 38,  p: 'h0001, frac: 2,  sat: 0, delta: 9,  ok: 0};
        tbl[5] = '{r: 50,  p: 'h7FFF, frac: 30, sat: 0, delta: 12, ok: 1};
        tbl[6] = '{r: 127, p: 'h0000, frac: 0,  sat: 0, delta: 77, ok: 0};
        tbl[7] = '{r: 3,   p: 'h0003, frac: 4,  sat: 0, delta: 4,  ok: 0};

        rst_n = 1'b0;
        en = 1'b0;
        ripple_count = '0;
        phase = '0;
        fcw_int = 7'd92;
        model_chk = 1'b1;
        model_reset();
        #12;
        all_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Startup: en seen at edge 0, first valid output after edge 7.
        en = 1'b1;
        phase = 16'h00FF;
        for (int j = 0; j < 11; j++) begin
            ripple_count = 7'((92 * j) & 127);
            edge_step();
            if (j <= 7) check("start_valid", int'(tdc_valid), (j == 7) ? 1 : 0);
            if (j == 7) begin
                check("start_frac",  int'(tdc_word[4:0]), 16);
                check("start_delta", int'(ckv_delta), 92);
                check("start_ok",    int'(freq_ok), 1);
            end
        end

        // Table of vectors in RUN with fcw_int=12.
        fcw_int = 7'd12;
        ripple_count = 7'd108;
        phase = 16'h0000;
        edge_step();
        for (int i = 0; i < 10; i++) begin
            if (i < 8) begin
                ripple_count = 7'(tbl[i].r);
                phase = 16'(tbl[i].p);
            end
            edge_step();
            if (i >= 2) begin
                check("tbl_word",  int'(tdc_word), tbl[i-2].r * 32 + tbl[i-2].frac);
                check("tbl_sat",   int'(therm_sat), tbl[i-2].sat);
                check("tbl_delta", int'(ckv_delta), tbl[i-2].delta);
                check("tbl_ok",    int'(freq_ok), tbl[i-2].ok);
                check("tbl_valid", int'(tdc_valid), 1);
            end
        end

        // Frequency window edges: delta 95 rejected, 94 accepted.
        fcw_int = 7'd92;
        phase = 16'h00FF;
        step_ripple(95); edge_step();
        step_ripple(94); edge_step();
        step_ripple(92); edge_step();
        check("win95_delta", int'(ckv_delta), 95);
        check("win95_ok",    int'(freq_ok), 0);
        step_ripple(92); edge_step();
        check("win94_delta", int'(ckv_delta), 94);
        check("win94_ok",    int'(freq_ok), 1);
        step_ripple(92); edge_step();

        // en drop at edge m: valid holds through m+2, clears from m+3.
        en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step_ripple(92);
            edge_step();
            check("drop_valid", int'(tdc_valid), (i <= 2) ? 1 : 0);
            if (i >= 3) check("drop_ok", int'(freq_ok), 0);
        end

        // Reach RUN again, then assert reset between edges.
        en = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step_ripple(92);
            edge_step();
        end
        check("pre_rst_valid", int'(tdc_valid), 1);
        #2;
        rst_n = 1'b0;
        #1;
        all_zero("async_rst");
        @(posedge clk);
        @(negedge clk);
        model_reset();
        rst_n = 1'b1;
        for (int j = 0; j < 8; j++) begin
            step_ripple(92);
            edge_step();
            check("rst_seq_valid", int'(tdc_valid), (j == 7) ? 1 : 0);
        end

        // Randomized traffic in two fcw segments.
        for (int seg = 0; seg < 2; seg++) begin
            en = 1'b0;
            for (int i = 0; i < 3; i++) edge_step();
            fcw_int = (seg == 0) ? 7'd37 : 7'd100;
            x = 0;
            for (int i = 0; i < 300; i++) begin
                if (x > 0) begin
                    x--;
                    en = 1'b0;
                end else if ($urandom_range(0, 24) == 0) begin
                    x = int'($urandom_range(0, 3));
                    en = 1'b0;
                end else begin
                    en = 1'b1;
                end
                if ($urandom_range(0, 15) == 0)
                    ripple_count = 7'($urandom_range(0, 127));
                else
                    step_ripple(int'(fcw_int) + int'($urandom_range(0, 6)) - 3);
                if ($urandom_range(0, 3) == 0)
                    phase = 16'($urandom_range(0, 65535));
                else
                    phase = 16'((32'h1 << $urandom_range(0, 16)) - 1);
                edge_step();
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
